// File: rtl/ac97_cmd_pkg.sv
// ---------------------------------------------------------------------------
// ac97_cmd_pkg
//   Shared definitions for the AC'97 codec command scheduler:
//     - codec register address constants and fixed init data words
//     - scheduler state enum (WAIT, INIT, IDLE)
//     - init ROM length and ROM lookup
//     - volume / record-select data encoders
//   Build option used by the scheduler: AC97_CMD_REFRESH_EN (see ac97_cmd_sched).
// ---------------------------------------------------------------------------
package ac97_cmd_pkg;

    // Codec register addresses
    localparam logic [7:0] ADDR_MASTER    = 8'h02;
    localparam logic [7:0] ADDR_HEADPHONE = 8'h04;
    localparam logic [7:0] ADDR_PCM_OUT   = 8'h18;
    localparam logic [7:0] ADDR_REC_SEL   = 8'h1A;
    localparam logic [7:0] ADDR_REC_GAIN  = 8'h1C;
    localparam logic [7:0] ADDR_MIC       = 8'h0E;

    // Fixed data words written during init
    localparam logic [15:0] DATA_PCM_OUT  = 16'h0808;
    localparam logic [15:0] DATA_REC_SEL0 = 16'h0000;
    localparam logic [15:0] DATA_REC_GAIN = 16'h0000;
    localparam logic [15:0] DATA_MIC      = 16'h0008;

    // Number of entries in the init ROM
    localparam int INIT_LEN = 6;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        INIT = 2'd1,
        IDLE = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } cmd_t;

    // Volume 0 is mute, 31 is loudest; the codec wants attenuation, so the
    // value is inverted and replicated into both channel fields.
    function automatic logic [15:0] vol_encode(input logic [4:0] volume);
        logic [4:0] atten;
        atten = 5'd31 - volume;
        return {(volume == 5'd0), 2'b00, atten, 3'b000, atten};
    endfunction

    // Same select code for left and right record channels.
    function automatic logic [15:0] src_encode(input logic [2:0] rec_src);
        return {5'b0, rec_src, 5'b0, rec_src};
    endfunction

    // Init ROM: master and headphone follow the live volume input.
    function automatic cmd_t init_rom(input logic [2:0] idx, input logic [4:0] volume);
        cmd_t c;
        case (idx)
            3'd0:    c = '{addr: ADDR_MASTER,    data: vol_encode(volume)};
            3'd1:    c = '{addr: ADDR_HEADPHONE, data: vol_encode(volume)};
            3'd2:    c = '{addr: ADDR_PCM_OUT,   data: DATA_PCM_OUT};
            3'd3:    c = '{addr: ADDR_REC_SEL,   data: DATA_REC_SEL0};
            3'd4:    c = '{addr: ADDR_REC_GAIN,  data: DATA_REC_GAIN};
            3'd5:    c = '{addr: ADDR_MIC,       data: DATA_MIC};
            default: c = '{addr: 8'h00,          data: 16'h0000};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ac97_ready_sync.sv
// ---------------------------------------------------------------------------
// ac97_ready_sync
//   Brings the link controller's frame-ready strobe into the clock domain
//   with a 2-FF synchronizer and turns each rising edge into a one-clock
//   tick.
//   Ports:
//     clock - system clock (rising edge)
//     reset - asynchronous active-high reset, clears all flops
//     ready - frame-ready strobe, asynchronous to clock
//     tick  - one clock wide pulse per ready rising edge
// ---------------------------------------------------------------------------
module ac97_ready_sync (
    input  logic clock,
    input  logic reset,
    input  logic ready,
    output logic tick
);

    logic sync_a;
    logic sync_b;
    logic sync_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_a    <= ready;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
        end
    end

    // Edge detect only on fully synchronized samples
    assign tick = sync_b & ~sync_prev;

endmodule

// File: rtl/ac97_cmd_sched.sv
// ---------------------------------------------------------------------------
// ac97_cmd_sched
//   Schedules AC'97 codec register writes, one per frame tick. After reset
//   it idles WAIT_FRAMES ticks, runs a 6-entry init ROM, raises init_done,
//   then serves volume / record-select requests (volume first; the 0x02 /
//   0x04 volume pair is never split).
//
//   Build option:
//     AC97_CMD_REFRESH_EN - when defined, an idle counter reissues the master
//                           volume every REFRESH_FRAMES ticks in IDLE while
//                           no request is pending. Undefined: idle ticks
//                           issue nothing.
//
//   Parameters:
//     WAIT_FRAMES    - ticks to idle after reset before init (>= 1)
//     REFRESH_FRAMES - ticks between refresh writes (>= 1)
//
//   Ports:
//     clock           - system clock (rising edge)
//     reset           - asynchronous active-high reset
//     ready           - frame-ready strobe (asynchronous)
//     volume          - requested volume, 0 = mute, 31 = loudest
//     vol_req         - level request to apply volume, held until vol_ack
//     rec_src         - record-select code
//     src_req         - level request to apply rec_src, held until src_ack
//     command_address - codec register address
//     command_data    - codec register data
//     command_valid   - command goes out in the next frame
//     vol_ack         - one-clock pulse when the volume pair completes
//     src_ack         - one-clock pulse when record-select is issued
//     init_done       - high once the init sequence has completed
// ---------------------------------------------------------------------------
module ac97_cmd_sched
    import ac97_cmd_pkg::*;
#(
    parameter int WAIT_FRAMES    = 4,
    parameter int REFRESH_FRAMES = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ready,
    input  logic [4:0]  volume,
    input  logic        vol_req,
    input  logic [2:0]  rec_src,
    input  logic        src_req,
    output logic [7:0]  command_address,
    output logic [15:0] command_data,
    output logic        command_valid,
    output logic        vol_ack,
    output logic        src_ack,
    output logic        init_done
);

    // Elaboration-time sanity check on the frame counts
    if (WAIT_FRAMES < 1 || REFRESH_FRAMES < 1) begin : g_bad_param
        $error("ac97_cmd_sched: WAIT_FRAMES and REFRESH_FRAMES must be >= 1");
    end

    localparam int WAIT_W = (WAIT_FRAMES > 1) ? $clog2(WAIT_FRAMES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_FRAMES - 1);
    localparam logic [2:0] IDX_DONE = 3'(INIT_LEN);

`ifdef AC97_CMD_REFRESH_EN
    localparam int REF_W = (REFRESH_FRAMES > 1) ? $clog2(REFRESH_FRAMES) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_FRAMES - 1);
`endif

    logic              tick;
    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        idx;
    // Set after the master write of a volume pair; headphone write follows
    logic              vol_second;
`ifdef AC97_CMD_REFRESH_EN
    logic [REF_W-1:0]  ref_cnt;
`endif

    ac97_ready_sync u_ready_sync (
        .clock (clock),
        .reset (reset),
        .ready (ready),
        .tick  (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= WAIT;
            wait_cnt        <= '0;
            idx             <= '0;
            vol_second      <= 1'b0;
            command_address <= '0;
            command_data    <= '0;
            command_valid   <= 1'b0;
            vol_ack         <= 1'b0;
            src_ack         <= 1'b0;
            init_done       <= 1'b0;
`ifdef AC97_CMD_REFRESH_EN
            ref_cnt         <= '0;
`endif
        end else begin
            // Acks are single-clock pulses
            vol_ack <= 1'b0;
            src_ack <= 1'b0;

            if (tick) begin
                case (state)
                    WAIT: begin
                        command_valid <= 1'b0;
                        if (wait_cnt == WAIT_LAST) begin
                            wait_cnt <= '0;
                            idx      <= '0;
                            state    <= INIT;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end

                    INIT: begin
                        if (idx == IDX_DONE) begin
                            // Completion tick: flag done, send nothing
                            command_valid <= 1'b0;
                            init_done     <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            {command_address, command_data} <= init_rom(idx, volume);
                            command_valid <= 1'b1;
                            idx           <= idx + 1'b1;
                        end
                    end

                    IDLE: begin
                        command_valid <= 1'b0;
`ifdef AC97_CMD_REFRESH_EN
                        // Saturates so a refresh blocked by requests fires
                        // on the first free tick.
                        if (ref_cnt != REF_LAST) begin
                            ref_cnt <= ref_cnt + 1'b1;
                        end
`endif
                        if (vol_second) begin
                            // Pair always completes; ack only if still wanted
                            command_address <= ADDR_HEADPHONE;
                            command_data    <= vol_encode(volume);
                            command_valid   <= 1'b1;
                            vol_second      <= 1'b0;
                            vol_ack         <= vol_req;
                        end else if (vol_req) begin
                            command_address <= ADDR_MASTER;
                            command_data    <= vol_encode(volume);
                            command_valid   <= 1'b1;
                            vol_second      <= 1'b1;
                        end else if (src_req) begin
                            command_address <= ADDR_REC_SEL;
                            command_data    <= src_encode(rec_src);
                            command_valid   <= 1'b1;
                            src_ack         <= 1'b1;
                        end
`ifdef AC97_CMD_REFRESH_EN
                        else if (ref_cnt == REF_LAST) begin
                            command_address <= ADDR_MASTER;
                            command_data    <= vol_encode(volume);
                            command_valid   <= 1'b1;
                            ref_cnt         <= '0;
                        end
`endif
                    end

                    default: begin
                        command_valid <= 1'b0;
                        state         <= WAIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ac97_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_ac97_cmd_sched
//   Directed and randomized frames against a tick-numbered reference model.
// ---------------------------------------------------------------------------
module tb_ac97_cmd_sched;

    localparam int WAIT_N = 4;
    localparam int REF_N  = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ready = 1'b0;
    logic [4:0]  volume = 5'd0;
    logic        vol_req = 1'b0;
    logic [2:0]  rec_src = 3'd0;
    logic        src_req = 1'b0;
    logic [7:0]  command_address;
    logic [15:0] command_data;
    logic        command_valid;
    logic        vol_ack;
    logic        src_ack;
    logic        init_done;

    ac97_cmd_sched #(
        .WAIT_FRAMES    (WAIT_N),
        .REFRESH_FRAMES (REF_N)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ready           (ready),
        .volume          (volume),
        .vol_req         (vol_req),
        .rec_src         (rec_src),
        .src_req         (src_req),
        .command_address (command_address),
        .command_data    (command_data),
        .command_valid   (command_valid),
        .vol_ack         (vol_ack),
        .src_ack         (src_ack),
        .init_done       (init_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Ack pulse counters sampled on the falling edge
    int vol_ack_cnt = 0;
    int src_ack_cnt = 0;
    always @(negedge clock) begin
        if (vol_ack) vol_ack_cnt++;
        if (src_ack) src_ack_cnt++;
    end

    // Reference model state
    logic [7:0]  rom_addr [6] = '{8'h02, 8'h04, 8'h18, 8'h1A, 8'h1C, 8'h0E};
    logic [15:0] rom_fixed[6] = '{16'h0, 16'h0, 16'h0808, 16'h0000, 16'h0000, 16'h0008};
    int          m_n, m_k, m_last;
    bit          m_pair;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
    logic        exp_valid, exp_done;
    int          exp_vack, exp_sack;

    function automatic logic [15:0] model_vol(input int v);
        int a;
        a = 31 - v;
        return 16'((v == 0 ? 32'h8000 : 32'h0) + a * 256 + a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_k = 0; m_last = 0; m_pair = 0;
        exp_addr = 8'h00; exp_data = 16'h0000; exp_valid = 1'b0; exp_done = 1'b0;
    endtask

    // One frame as the model sees it, using the inputs present at the tick
    task automatic model_tick();
        int i;
        m_n++;
        exp_valid = 1'b0; exp_vack = 0; exp_sack = 0;
        if (m_n <= WAIT_N) begin
            // waiting
        end else if (m_n <= WAIT_N + 6) begin
            i = m_n - WAIT_N - 1;
            exp_addr  = rom_addr[i];
            exp_data  = (i < 2) ? model_vol(int'(volume)) : rom_fixed[i];
            exp_valid = 1'b1;
        end else if (m_n == WAIT_N + 7) begin
            exp_done = 1'b1;
        end else begin
            m_k++;
            if (m_pair) begin
                exp_addr = 8'h04; exp_data = model_vol(int'(volume)); exp_valid = 1'b1;
                exp_vack = vol_req ? 1 : 0;
                m_pair   = 0;
            end else if (vol_req) begin
                exp_addr = 8'h02; exp_data = model_vol(int'(volume)); exp_valid = 1'b1;
                m_pair   = 1;
            end else if (src_req) begin
                exp_addr = 8'h1A; exp_data = {5'b0, rec_src, 5'b0, rec_src}; exp_valid = 1'b1;
                exp_sack = 1;
            end
`ifdef AC97_CMD_REFRESH_EN
            else if (m_k - m_last >= REF_N) begin
                exp_addr = 8'h02; exp_data = model_vol(int'(volume)); exp_valid = 1'b1;
                m_last   = m_k;
            end
`endif
        end
    endtask

    // Drive one ready pulse, then compare all outputs against the model.
    // The requester drops a request once it has been acknowledged.
    task automatic step(input string tag);
        int va0, sa0;
        va0 = vol_ack_cnt; sa0 = src_ack_cnt;
        #3 ready = 1'b1;
        repeat (4) @(posedge clock);
        #3 ready = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        model_tick();
        check({tag, ".valid"}, 32'(command_valid), 32'(exp_valid));
        check({tag, ".addr"},  32'(command_address), 32'(exp_addr));
        check({tag, ".data"},  32'(command_data), 32'(exp_data));
        check({tag, ".done"},  32'(init_done), 32'(exp_done));
        check({tag, ".vack"},  32'(vol_ack_cnt - va0), 32'(exp_vack));
        check({tag, ".sack"},  32'(src_ack_cnt - sa0), 32'(exp_sack));
        if (exp_vack != 0) vol_req = 1'b0;
        if (exp_sack != 0) src_req = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".addr"},  32'(command_address), 32'h0);
        check({tag, ".data"},  32'(command_data), 32'h0);
        check({tag, ".valid"}, 32'(command_valid), 32'h0);
        check({tag, ".vack"},  32'(vol_ack), 32'h0);
        check({tag, ".sack"},  32'(src_ack), 32'h0);
        check({tag, ".done"},  32'(init_done), 32'h0);
    endtask

    initial begin
        model_reset();
        // Asynchronous reset: outputs clear without a clock edge
        #1 reset = 1'b1;
        #2 check_zero("reset");
        repeat (3) @(posedge clock);
        #3 reset = 1'b0;

        // Init sequence with volume 20
        volume = 5'd20;
        for (int f = 0; f < WAIT_N + 7; f++) step("init");

        // Loudest volume pair
        volume = 5'd31; vol_req = 1'b1;
        for (int f = 0; f < 3; f++) step("vol31");

        // Mute volume pair
        volume = 5'd0; vol_req = 1'b1;
        for (int f = 0; f < 3; f++) step("vol0");

        // Simultaneous requests: volume pair first, then record select
        volume = 5'd15; vol_req = 1'b1; rec_src = 3'd4; src_req = 1'b1;
        for (int f = 0; f < 4; f++) step("both");

        // Record select withdrawn before it is served: no ack
        volume = 5'd7; vol_req = 1'b1; rec_src = 3'd5; src_req = 1'b1;
        step("drop.a");
        step("drop.b");
        src_req = 1'b0;
        step("drop.c");

        // Reset mid-init, with requests left pending across the rerun
        #1 reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        for (int f = 0; f < WAIT_N + 4; f++) step("rerun0");
        #1 reset = 1'b1;
        #1 check_zero("midreset");
        model_reset();
        repeat (2) @(posedge clock);
        volume = 5'd10; vol_req = 1'b1; rec_src = 3'd2; src_req = 1'b1;
        #3 reset = 1'b0;
        for (int f = 0; f < WAIT_N + 11; f++) step("rerun");

        // Randomized requests
        for (int f = 0; f < 150; f++) begin
            if (!vol_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    volume  = 5'($urandom_range(0, 31));
                    vol_req = 1'b1;
                end
            end else if (!m_pair && $urandom_range(0, 7) == 0) begin
                vol_req = 1'b0;
            end
            if (!src_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    rec_src = 3'($urandom_range(0, 7));
                    src_req = 1'b1;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                src_req = 1'b0;
            end
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
